// File: rtl/mem_arbiter_2port.sv
// mem_arbiter_2port: two-port round-robin arbiter/sequencer for a single-ported memory.
// Define ARB_FIXED_PRIO_EN to make port 0 always win simultaneous requests.
module mem_arbiter_2port #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_wr,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_wr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic last_q, last_d, own_q, own_d, win1;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, rv0_q, rv0_d, rv1_q, rv1_d;
  logic mem_en_q, mem_en_d, mem_wr_q, mem_wr_d, busy_q, busy_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
`ifdef ARB_FIXED_PRIO_EN
  assign win1 = !p0_req;
`else
  // port 1 wins a tie only when port 0 was granted last
  assign win1 = p1_req && (!p0_req || !last_q);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    own_d = own_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    rv0_d = 1'b0;
    rv1_d = 1'b0;
    mem_en_d = 1'b0;
    mem_wr_d = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (p0_req || p1_req) begin
        own_d = win1;
`ifndef ARB_FIXED_PRIO_EN
        last_d = win1;
`endif
        gnt0_d = !win1;
        gnt1_d = win1;
        mem_en_d = 1'b1;
        mem_wr_d = win1 ? p1_wr : p0_wr;
        mem_addr_d = win1 ? p1_addr : p0_addr;
        mem_wdata_d = win1 ? p1_wdata : p0_wdata;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = mem_wr_q ? cnt_q : 4'(MEM_LAT - 1);
        state_d = mem_wr_q ? IDLE : WAIT;
      end
      WAIT: if (cnt_q == 4'd0) begin
        rv0_d = !own_q;
        rv1_d = own_q;
        rdata0_d = own_q ? rdata0_q : mem_q;
        rdata1_d = own_q ? mem_q : rdata1_q;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      own_q <= 1'b0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      own_q <= own_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      rv0_q <= rv0_d;
      rv1_q <= rv1_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q <= busy_d;
    end
  end
  assign p0_gnt = gnt0_q;
  assign p1_gnt = gnt1_q;
  assign p0_rvalid = rv0_q;
  assign p1_rvalid = rv1_q;
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;
  assign mem_en = mem_en_q;
  assign mem_wr = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_mem_arbiter_2port.sv
// tb_mem_arbiter_2port: scoreboard bench; main DUT at MEM_LAT=2 plus MEM_LAT=1/15 instances.
module tb_mem_arbiter_2port;
  localparam int LAT = 2;
  logic clk = 0, rst_n = 0;
  int cyc = 0, total = 0, bad = 0;
  logic p0_req = 0, p0_wr = 0, p1_req = 0, p1_wr = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en, mem_wr, busy;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_q;
  logic l_req = 0, l_wr = 0;
  logic [31:0] l_addr = 0, l_wdata = 0;
  logic a_gnt, a_rv, a_en, a_wr, a_busy, a_g1, a_v1;
  logic b_gnt, b_rv, b_en, b_wr, b_busy, b_g1, b_v1;
  logic [31:0] a_rd, a_addr, a_wd, a_q, a_r1, b_rd, b_addr, b_wd, b_q, b_r1;
  logic [31:0] pm [LAT];
  logic [31:0] pa [1];
  logic [31:0] pb [15];
  typedef struct {logic port; logic wr; logic [31:0] addr; logic [31:0] wdata;} gexp_t;
  gexp_t gq[$];
  logic [31:0] dq0[$], dq1[$];
  int tq0[$], tq1[$];

  mem_arbiter_2port #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_q(mem_q), .busy(busy));
  mem_arbiter_2port #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .p0_req(l_req), .p0_wr(l_wr), .p0_addr(l_addr), .p0_wdata(l_wdata),
    .p0_gnt(a_gnt), .p0_rvalid(a_rv), .p0_rdata(a_rd),
    .p1_req(1'b0), .p1_wr(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
    .p1_gnt(a_g1), .p1_rvalid(a_v1), .p1_rdata(a_r1),
    .mem_en(a_en), .mem_wr(a_wr), .mem_addr(a_addr), .mem_wdata(a_wd),
    .mem_q(a_q), .busy(a_busy));
  mem_arbiter_2port #(.AW(32), .DW(32), .MEM_LAT(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n),
    .p0_req(l_req), .p0_wr(l_wr), .p0_addr(l_addr), .p0_wdata(l_wdata),
    .p0_gnt(b_gnt), .p0_rvalid(b_rv), .p0_rdata(b_rd),
    .p1_req(1'b0), .p1_wr(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
    .p1_gnt(b_g1), .p1_rvalid(b_v1), .p1_rdata(b_r1),
    .mem_en(b_en), .mem_wr(b_wr), .mem_addr(b_addr), .mem_wdata(b_wd),
    .mem_q(b_q), .busy(b_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory contents: 0x10 holds 0xDEADBEEF, other words hold {~addr[15:0], addr[15:0]}
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
  endfunction
  always @(posedge clk) begin
    pm[0] <= (mem_en && !mem_wr) ? mdata(mem_addr) : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) pm[i] <= pm[i-1];
  end
  always @(posedge clk) pa[0] <= (a_en && !a_wr) ? mdata(a_addr) : 32'hBAD0BAD0;
  always @(posedge clk) begin
    pb[0] <= (b_en && !b_wr) ? mdata(b_addr) : 32'hBAD0BAD0;
    for (int j = 1; j < 15; j++) pb[j] <= pb[j-1];
  end
  assign mem_q = pm[LAT-1];
  assign a_q = pa[0];
  assign b_q = pb[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops grant and read-return expectations as the DUT presents them
  always @(negedge clk) if (rst_n) begin
    gexp_t e;
    if (p0_gnt && p1_gnt) chk("gnt_exclusive", 32'd1, 32'd0);
    if (p0_rvalid && p1_rvalid) chk("rvalid_exclusive", 32'd1, 32'd0);
    if (p0_gnt || p1_gnt || mem_en) begin
      chk("mem_en_with_gnt", {31'd0, mem_en}, {31'd0, p0_gnt || p1_gnt});
      if (gq.size() == 0) chk("gnt_unexpected", {31'd0, p1_gnt}, 32'hFFFFFFFF);
      else begin
        e = gq.pop_front();
        chk("gnt_port", {31'd0, p1_gnt}, {31'd0, e.port});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
        chk("mem_addr", mem_addr, e.addr);
        if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
        else if (e.port) tq1.push_back(cyc + LAT + 1);
        else tq0.push_back(cyc + LAT + 1);
      end
    end
    if (p0_rvalid) begin
      if (dq0.size() == 0 || tq0.size() == 0) chk("p0_rvalid_unexpected", p0_rdata, 32'hFFFFFFFF);
      else begin
        chk("p0_rdata", p0_rdata, dq0.pop_front());
        chk("p0_rvalid_cycle", cyc, tq0.pop_front());
      end
    end
    if (p1_rvalid) begin
      if (dq1.size() == 0 || tq1.size() == 0) chk("p1_rvalid_unexpected", p1_rdata, 32'hFFFFFFFF);
      else begin
        chk("p1_rdata", p1_rdata, dq1.pop_front());
        chk("p1_rvalid_cycle", cyc, tq1.pop_front());
      end
    end
  end

  task automatic expg(input logic p, input logic wr, input logic [31:0] a, input logic [31:0] w);
    gexp_t e;
    e.port = p; e.wr = wr; e.addr = a; e.wdata = w;
    gq.push_back(e);
  endtask

  // raise a request at a negedge, hold it until gnt is seen, then drop it
  task automatic issue(input logic p, input logic wr, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] d, output int n);
    if (!wr) begin
      if (p) dq1.push_back(d);
      else dq0.push_back(d);
    end
    if (p) begin p1_wr = wr; p1_addr = a; p1_wdata = w; p1_req = 1; end
    else begin p0_wr = wr; p0_addr = a; p0_wdata = w; p0_req = 1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? p1_gnt : p0_gnt) && n < 50);
    if (!(p ? p1_gnt : p0_gnt)) chk("gnt_timeout", 32'd0, 32'd1);
    if (p) p1_req = 0;
    else p0_req = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin @(negedge clk); k++; end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n, m, r1, r15, c0, extra;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
    rst_n = 1;
    @(negedge clk);
    // single read
    expg(0, 0, 32'h10, 0);
    issue(0, 0, 32'h10, 0, 32'hDEADBEEF, n);
    chk("rd_gnt_cycle", n, 32'd1);
    wait_idle();
    // single write: no rvalid, back in IDLE next cycle
    expg(1, 1, 32'h20, 32'hCAFE0001);
    issue(1, 1, 32'h20, 32'hCAFE0001, 0, n);
    chk("wr_gnt_cycle", n, 32'd1);
    @(negedge clk);
    chk("wr_busy_c2", {31'd0, busy}, 32'd0);
    // held read data survives writes and the other port's read
    expg(0, 1, 32'h24, 32'h12345678);
    issue(0, 1, 32'h24, 32'h12345678, 0, n);
    wait_idle();
    chk("p0_rdata_hold_wr", p0_rdata, 32'hDEADBEEF);
    expg(1, 0, 32'h30, 0);
    issue(1, 0, 32'h30, 0, 32'hFFCF0030, n);
    wait_idle();
    chk("p0_rdata_hold_rd", p0_rdata, 32'hDEADBEEF);
    // tie with continuous reads
`ifdef ARB_FIXED_PRIO_EN
    expg(0, 0, 32'h100, 0); expg(0, 0, 32'h104, 0);
    expg(1, 0, 32'h200, 0); expg(1, 0, 32'h204, 0);
`else
    expg(0, 0, 32'h100, 0); expg(1, 0, 32'h200, 0);
    expg(0, 0, 32'h104, 0); expg(1, 0, 32'h204, 0);
`endif
    fork
      begin issue(0, 0, 32'h100, 0, 32'hFEFF0100, n); issue(0, 0, 32'h104, 0, 32'hFEFB0104, n); end
      begin issue(1, 0, 32'h200, 0, 32'hFDFF0200, m); issue(1, 0, 32'h204, 0, 32'hFDFB0204, m); end
    join
    wait_idle();
    // reset in the middle of a read's WAIT
    expg(0, 0, 32'h40, 0);
    issue(0, 0, 32'h40, 0, 32'hFFBF0040, n);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rdata", p0_rdata | p1_rdata, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_strobes", {28'd0, mem_en, p0_gnt, p1_gnt, p0_rvalid}, 32'd0);
    dq0.delete(); tq0.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    expg(0, 0, 32'h60, 0); expg(1, 0, 32'h70, 0);
    fork
      issue(0, 0, 32'h60, 0, 32'hFF9F0060, n);
      issue(1, 0, 32'h70, 0, 32'hFF8F0070, m);
    join
    wait_idle();
    // latency sweep on the MEM_LAT=1 and MEM_LAT=15 instances
    l_wr = 0; l_addr = 32'h50; l_req = 1; c0 = cyc + 1; r1 = 0; r15 = 0;
    for (int k = 0; k < 30 && (r1 == 0 || r15 == 0); k++) begin
      @(negedge clk);
      if (a_gnt) l_req = 0;
      if (a_rv && r1 == 0) r1 = cyc - c0 + 1;
      if (b_rv && r15 == 0) r15 = cyc - c0 + 1;
    end
    l_req = 0;
    chk("lat1_cycle", r1, 32'd3);
    chk("lat15_cycle", r15, 32'd17);
    chk("lat1_rdata", a_rd, 32'hFFAF0050);
    chk("lat15_rdata", b_rd, 32'hFFAF0050);
    l_wr = 1; l_wdata = 32'h11111111; l_req = 1; extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_gnt) l_req = 0;
      if (a_rv || b_rv) extra++;
    end
    l_req = 0;
    chk("lat_wr_no_rvalid", extra, 32'd0);
    chk("lat1_rdata_hold", a_rd, 32'hFFAF0050);
    chk("lat15_rdata_hold", b_rd, 32'hFFAF0050);
    repeat (4) @(negedge clk);
    chk("left_gnt", gq.size(), 32'd0);
    chk("left_rd", dq0.size() + dq1.size() + tq0.size() + tq1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
